// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_write_arbiter
//  Purpose  : Owns the single write port of register_bank. After reset it
//             writes INIT_VALUE into every register. It then shares the port
//             between two writeback requesters using valid/ready handshakes
//             and round-robin priority.
//  Ports    : clk, reset            - clock, synchronous active-high reset
//             req{0,1}Valid/Reg/Data - requester write request
//             req{0,1}Ready          - requester accepted this cycle
//             regWrite/writeRegister/writeData - register_bank write port
//             initDone               - init sweep finished (until next reset)
//             grantId                - most recently granted requester
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter #(
    parameter int                NUM_REGS   = 32,
    parameter int                ADDR_W     = 5,
    parameter int                DATA_W     = 32,
    parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              req0Valid,
    input  logic [ADDR_W-1:0] req0Reg,
    input  logic [DATA_W-1:0] req0Data,
    output logic              req0Ready,

    input  logic              req1Valid,
    input  logic [ADDR_W-1:0] req1Reg,
    input  logic [DATA_W-1:0] req1Data,
    output logic              req1Ready,

    output logic              regWrite,
    output logic [ADDR_W-1:0] writeRegister,
    output logic [DATA_W-1:0] writeData,
    output logic              initDone,
    output logic              grantId
);

    // The init counter must be able to hold NUM_REGS itself: that value marks
    // the extra edge on which init hands over to RUN.
    localparam int CNT_W = $clog2(NUM_REGS + 1);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_ptr;      // requester favoured when both are valid

    logic              w_run;
    logic              w_both;
    logic              w_gid;
    logic              w_xfer;
    logic [ADDR_W-1:0] w_sel_reg;
    logic [DATA_W-1:0] w_sel_data;

    // ------------------------------------------------------------------------
    // Arbitration. A lone valid requester wins regardless of the pointer so
    // the port never idles while work is pending; the pointer only breaks
    // ties.
    // ------------------------------------------------------------------------
    always_comb begin
        w_run  = (r_state == ST_RUN);
        w_both = req0Valid & req1Valid;
        if (w_both) begin
            w_gid = r_ptr;
        end else begin
            w_gid = req1Valid;
        end
        w_xfer     = w_run & (req0Valid | req1Valid);
        w_sel_reg  = w_gid ? req1Reg  : req0Reg;
        w_sel_data = w_gid ? req1Data : req0Data;
    end

    // Ready depends only on valid, state and pointer - never on ready itself.
    assign req0Ready = w_run & req0Valid & ~w_gid;
    assign req1Ready = w_run & req1Valid &  w_gid;

    // ------------------------------------------------------------------------
    // Sequencer / write-port registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_INIT;
            r_cnt         <= '0;
            r_ptr         <= 1'b0;
            regWrite      <= 1'b0;
            writeRegister <= '0;
            writeData     <= '0;
            initDone      <= 1'b0;
            grantId       <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    if (r_cnt == CNT_W'(NUM_REGS)) begin
                        // Last register was presented on the previous edge.
                        r_state  <= ST_RUN;
                        regWrite <= 1'b0;
                        initDone <= 1'b1;
                    end else begin
                        regWrite      <= 1'b1;
                        writeRegister <= ADDR_W'(r_cnt);
                        writeData     <= INIT_VALUE;
                        r_cnt         <= r_cnt + CNT_W'(1);
                    end
                end

                ST_RUN: begin
                    if (w_xfer) begin
                        writeRegister <= w_sel_reg;
                        writeData     <= w_sel_data;
                        grantId       <= w_gid;
                        r_ptr         <= ~w_gid;
                        // Register 0 is architecturally constant: the request
                        // is accepted but never reaches the bank.
                        regWrite      <= (w_sel_reg != '0);
                    end else begin
                        // Address/data hold; only the enable drops.
                        regWrite <= 1'b0;
                    end
                end

                default: begin
                    r_state <= ST_INIT;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Sequencer and arbiter for the single write port of `register_bank`. After reset it walks every register and writes `INIT_VALUE`, so the bank starts in a known state. It then shares the one write port between two writeback requesters (port 0: ALU writeback, port 1: load writeback) using valid/ready handshakes and round-robin priority. It drives `regWrite`/`writeRegister`/`writeData` of `register_bank` directly. The read ports are not touched.

## Interface
- `NUM_REGS`, 32: number of registers to initialise, equal to the bank depth.
- `ADDR_W`, 5: register index width.
- `DATA_W`, 32: data width.
- `INIT_VALUE`, 0: value written to every register during init.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req0Valid`  in  1  requester 0 has a write pending.
- `req0Reg`  in  ADDR_W  requester 0 destination register.
- `req0Data`  in  DATA_W  requester 0 write data.
- `req0Ready`  out  1  requester 0 accepted this cycle.
- `req1Valid`, `req1Reg`, `req1Data`, `req1Ready`: same as port 0, for requester 1.
- `regWrite`  out  1  write enable to `register_bank`.
- `writeRegister`  out  ADDR_W  write address to `register_bank`.
- `writeData`  out  DATA_W  write data to `register_bank`.
- `initDone`  out  1  high once init has completed; stays high until the next reset.
- `grantId`  out  1  index of the most recently granted requester.

## Operation
- FSM states: INIT and RUN. Reset forces INIT, with init counter = 0 and priority pointer = 0.
- **INIT**
  - Each cycle: registered outputs `regWrite`=1, `writeRegister`=counter, `writeData`=INIT_VALUE; counter increments.
  - After counter value NUM_REGS-1 has been presented, the next edge enters RUN with `regWrite`=0 and `initDone`=1.
  - Both `reqNReady` stay 0 throughout INIT.
- **RUN arbitration** (combinational on valids, state and pointer)
  - If only one requester is valid, it is granted regardless of the pointer (work-conserving).
  - If both are valid, the requester named by the pointer is granted.
  - `reqNReady` = RUN and grant to N. At most one ready is high per cycle.
  - The pointer is set to the other requester only on a grant. No grant, no change.
- **Transfer.** A transfer happens on an edge where valid & ready are both high. At that edge:
  - `writeRegister`←reqReg, `writeData`←reqData, `grantId`←N.
  - `regWrite`←1, except when reqReg==0.
- **Register 0.** A RUN request to register 0 is accepted (ready=1) but discarded: `regWrite`=0 and register 0 keeps INIT_VALUE. INIT still writes register 0.
- **Idle cycles.** A cycle with no transfer loads `regWrite`←0. `writeRegister`/`writeData` hold their previous values.
- **Requester rule.** A requester holds `reqNValid`, `reqNReg` and `reqNData` stable until ready. Dropping valid before ready is not allowed.
- **Same-register conflicts.** When both requesters target the same register, the two writes are serialised in grant order. The last grant wins; no merging.
- **Reset mid-operation.** The next edge returns the block to INIT from register 0 with every output at its reset value. A write in flight is lost and init reruns completely.

## Timing
- **Reset values:** `regWrite`=0, `writeRegister`=0, `writeData`=0, `initDone`=0, `grantId`=0, `req0Ready`=`req1Ready`=0.
- **Init sequence.** E0 is the first edge with `reset` sampled low.
  - Edges E0..E(NUM_REGS-1) present registers 0..NUM_REGS-1.
  - The bank captures the write for register i at edge E(i+1).
  - At E(NUM_REGS), `initDone` rises and `regWrite` falls. Init occupies NUM_REGS+1 edges.
- **Write latency.** A handshake at edge T puts the write on the port during cycle T..T+1. The bank captures it at T+1, and a read of that register reflects the new data after T+1.
- **Throughput.** One accepted write per cycle, back-to-back. Under continuous dual requests, the grant sequence is 0,1,0,1,…
- `reqNReady` is combinational from valid, with no dependence on ready.

## Test plan
- **Init.** Reset high for 2 cycles, then low → `regWrite`=1 for 32 consecutive cycles with `writeRegister` 0..31 and `writeData`=0. Next, `initDone`=1 and `regWrite`=0. All 32 registers read 0.
- **Single requester.** After init, req0 {reg 1, data 12} → `req0Ready`=1 for one cycle; next cycle `regWrite`=1, `writeRegister`=1, `writeData`=12. `readData1` (readRegister1=1) = 12 after the following edge.
- **Continuous contention.** req0 {reg 3, 15} and req1 {reg 5, 20} held valid and reissued → grants 0,1,0,1 with `grantId` alternating. Reg 3 reads 15 and reg 5 reads 20.
- **Same-register conflict.** req0 {reg 3, 16} and req1 {reg 3, 17} asserted together once → req0 granted first, req1 next cycle. Reg 3 ends at 17; `grantId` ends at 1.
- **Register 0 discard.** req1 {reg 0, 99} → `req1Ready`=1, `regWrite` stays 0, reg 0 reads 0.
- **Reset during init.** Assert reset while `writeRegister`=10 → next edge all outputs at reset values. After release, init restarts at register 0, and ready stays 0 until `initDone`.
